// File: rtl/wide_stable_sync_register.sv
// wide_stable_sync_register
//
// Brings a quasi-static multi-bit bus (configuration word, mode select, slow
// counter) from a foreign clock domain into clk. Every bit passes through a
// STAGES-deep flop chain. The synchronised word is only committed to `out`
// once it has held one value for STABLE_CYCLES more cycles. Per-bit skew can
// therefore never show a half-old/half-new word on `out`.
//
// Parameters:
//   WIDTH         bus width (>= 1)
//   STAGES        synchroniser flops per bit (>= 2)
//   STABLE_CYCLES cycles the candidate must stay unchanged before commit (>= 1)
//   RESET_VALUE   value loaded into the sync chain, candidate and out on reset
//
// Ports:
//   clk           single clock; every register is in this domain
//   rst           asynchronous, active-high reset
//   in            asynchronous source bus
//   out           committed word; changes only on a commit
//   update        one-cycle registered pulse on every commit
//   busy          high while a candidate is settling. With a two-state FSM
//                 this is the registered state itself, so it doubles as the
//                 FSM state observation point.
//   reject_count  (only with WIDE_STABLE_SYNC_REJECT_COUNT_EN) saturating
//                 16-bit count of aborted or restarted candidates
//
// Optional feature macro: WIDE_STABLE_SYNC_REJECT_COUNT_EN
//
// Handshake: there is none. `in` is sampled every cycle with no valid/ready.
// `update` qualifies the cycle in which `out` takes a new value.

module wide_stable_sync_register #(
  parameter int                WIDTH         = 8,
  parameter int                STAGES        = 2,
  parameter int                STABLE_CYCLES = 4,
  parameter logic [WIDTH-1:0]  RESET_VALUE   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             update,
`ifdef WIDE_STABLE_SYNC_REJECT_COUNT_EN
  output logic             busy,
  output logic [15:0]      reject_count
`else
  output logic             busy
`endif
);

  localparam int             CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_SETTLING = 1'b1;

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [0:0]       state_q, state_d;
  logic             update_q, update_d;
  logic [WIDTH-1:0] s;

  assign s = sync_q[STAGES-1];

  always_comb begin
    sync_d[0] = in;
    for (int k = 1; k < STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // Priority in SETTLING: return-to-committed, then restart, then commit.
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    update_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s != out_q) begin
          cand_d  = s;
          cnt_d   = CNT_ONE;
          state_d = ST_SETTLING;
        end
      end
      ST_SETTLING: begin
        if (s == out_q) begin
          state_d = ST_IDLE;
        end else if (s != cand_q) begin
          cand_d = s;
          cnt_d  = CNT_ONE;
        end else if (cnt_q == CNT_MAX) begin
          out_d    = cand_q;
          update_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= RESET_VALUE;
      end
      cand_q   <= RESET_VALUE;
      out_q    <= RESET_VALUE;
      cnt_q    <= '0;
      state_q  <= ST_IDLE;
      update_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      cand_q   <= cand_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      update_q <= update_d;
    end
  end

  assign out    = out_q;
  assign update = update_q;
  assign busy   = (state_q == ST_SETTLING);

`ifdef WIDE_STABLE_SYNC_REJECT_COUNT_EN
  // An abort or a restart is exactly "settling and the word moved off cand".
  logic        reject;
  logic [15:0] reject_cnt_q, reject_cnt_d;

  assign reject = (state_q == ST_SETTLING) && ((s == out_q) || (s != cand_q));

  always_comb begin
    reject_cnt_d = reject_cnt_q;
    if (reject && (reject_cnt_q != 16'hFFFF)) begin
      reject_cnt_d = reject_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reject_cnt_q <= 16'd0;
    end else begin
      reject_cnt_q <= reject_cnt_d;
    end
  end

  assign reject_count = reject_cnt_q;
`endif

endmodule

// File: tb/tb_wide_stable_sync_register.sv
module tb_wide_stable_sync_register;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in  = 8'h00;
  logic [7:0] out;
  logic       update;
  logic       busy;
  logic [0:0] in2 = 1'b0;
  logic [0:0] out2;
  logic       update2;
  logic       busy2;
`ifdef WIDE_STABLE_SYNC_REJECT_COUNT_EN
  logic [15:0] reject_count;
  logic [15:0] reject_count2;
`endif

  always #5 clk = ~clk;

  wide_stable_sync_register dut (
    .clk          (clk),
    .rst          (rst),
    .in           (in),
    .out          (out),
    .update       (update),
`ifdef WIDE_STABLE_SYNC_REJECT_COUNT_EN
    .busy         (busy),
    .reject_count (reject_count)
`else
    .busy         (busy)
`endif
  );

  wide_stable_sync_register #(
    .WIDTH         (1),
    .STAGES        (3),
    .STABLE_CYCLES (1),
    .RESET_VALUE   (1'b0)
  ) dut2 (
    .clk          (clk),
    .rst          (rst),
    .in           (in2),
    .out          (out2),
    .update       (update2),
`ifdef WIDE_STABLE_SYNC_REJECT_COUNT_EN
    .busy         (busy2),
    .reject_count (reject_count2)
`else
    .busy         (busy2)
`endif
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] prev_out = 8'h00;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev_out = out;
      end else begin
        if (update) begin
          if (exp_q.size() == 0) begin
            check("sb_unexpected_update", {31'd0, update}, 32'd0);
          end else begin
            check("sb_commit", {24'd0, out}, {24'd0, exp_q.pop_front()});
          end
        end else if (out != prev_out) begin
          check("sb_out_without_update", {24'd0, out}, {24'd0, prev_out});
        end
        prev_out = out;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Edges are numbered from the first edge that captures the current `in`.
  // busy expected high for edges bs..be, commit at edge ce (0 = none).
  task automatic watch(input string name, input int k_from, input int k_to,
                       input int bs, input int be, input int ce,
                       input logic [7:0] old_v, input logic [7:0] new_v);
    for (int k = k_from; k <= k_to; k++) begin
      step();
      check($sformatf("%s_busy_e%0d", name, k), {31'd0, busy},
            {31'd0, (k >= bs && k <= be)});
      check($sformatf("%s_update_e%0d", name, k), {31'd0, update},
            {31'd0, (ce != 0 && k == ce)});
      check($sformatf("%s_out_e%0d", name, k), {24'd0, out},
            {24'd0, (ce != 0 && k >= ce) ? new_v : old_v});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout got=%0d exp=0", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    #1;
    check("rst_out", {24'd0, out}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_update", {31'd0, update}, 32'd0);
    step();
    rst = 1'b0;

    // Reset mid-settle, then commit after release with 0x5A held.
    in = 8'h5A;
    watch("pre_rst", 1, 4, 3, 6, 0, 8'h00, 8'h00);
    rst = 1'b1;
    #1;
    check("async_rst_out", {24'd0, out}, 32'h0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_update", {31'd0, update}, 32'd0);
    step();
    step();
    rst = 1'b0;
    exp_q.push_back(8'h5A);
    watch("post_rst", 1, 8, 3, 6, 7, 8'h00, 8'h5A);

    // Clean change.
    in = 8'h00;
    apply_reset();
`ifdef WIDE_STABLE_SYNC_REJECT_COUNT_EN
    check("rc_after_reset", {16'd0, reject_count}, 32'd0);
`endif
    in = 8'hA5;
    exp_q.push_back(8'hA5);
    watch("clean", 1, 9, 3, 6, 7, 8'h00, 8'hA5);

    // Glitch: 3 cycles of 0x3C, then back to 0x00.
    in = 8'h00;
    apply_reset();
    in = 8'h3C;
    watch("glitch", 1, 3, 3, 5, 0, 8'h00, 8'h00);
    in = 8'h00;
    watch("glitch", 4, 10, 3, 5, 0, 8'h00, 8'h00);
`ifdef WIDE_STABLE_SYNC_REJECT_COUNT_EN
    check("rc_glitch", {16'd0, reject_count}, 32'd1);
`endif

    // Bounce: 0x11 for 2 cycles, then 0x22 held.
    apply_reset();
    in = 8'h11;
    exp_q.push_back(8'h22);
    watch("bounce", 1, 2, 3, 8, 9, 8'h00, 8'h22);
    in = 8'h22;
    watch("bounce", 3, 10, 3, 8, 9, 8'h00, 8'h22);
`ifdef WIDE_STABLE_SYNC_REJECT_COUNT_EN
    check("rc_bounce", {16'd0, reject_count}, 32'd1);
`endif

    // Back-to-back: 0x01 held 10 cycles, then 0x02.
    in = 8'h00;
    apply_reset();
    in = 8'h01;
    exp_q.push_back(8'h01);
    watch("b2b_a", 1, 10, 3, 6, 7, 8'h00, 8'h01);
    in = 8'h02;
    exp_q.push_back(8'h02);
    watch("b2b_b", 1, 10, 3, 6, 7, 8'h01, 8'h02);

    // Random quasi-static values, each held long enough to commit.
    for (int i = 0; i < 4; i++) begin
      logic [7:0] prev_v;
      logic [7:0] v;
      prev_v = in;
      v = 8'($urandom_range(1, 255));
      if (v == prev_v) v = prev_v ^ 8'h80;
      in = v;
      exp_q.push_back(v);
      watch($sformatf("rand%0d", i), 1, 8, 3, 6, 7, prev_v, v);
    end

    // Parameter sweep instance: STAGES=3, STABLE_CYCLES=1, WIDTH=1.
    in = 8'h00;
    apply_reset();
    in2 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("sweep_out_e%0d", k), {31'd0, out2}, {31'd0, (k >= 5)});
      check($sformatf("sweep_update_e%0d", k), {31'd0, update2}, {31'd0, (k == 5)});
      check($sformatf("sweep_busy_e%0d", k), {31'd0, busy2}, {31'd0, (k == 4)});
    end

    step();
    check("sb_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
